// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO and a valid/ready write port.
// Frame layout, baud divisor and FIFO depth are set by parameters.
module uart_tx_fifo #(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_BITS-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   frame_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [LW-1:0] FULL      = LW'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic                 push, pop;

    state_t               state, state_n;
    logic [CW-1:0]        baud_cnt, baud_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par_bit, par_n;
    logic                 tx_n;
    logic                 baud_last;

    assign in_ready  = (level < FULL);
    assign push      = in_valid && in_ready;
    assign head      = mem[rd_ptr];
    assign busy      = (state != ST_IDLE) || (level != '0);
    assign baud_last = (baud_cnt == BAUD_LAST);

    // NOTE: FIFO storage has no reset; pointers and level alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_n    = state;
        bit_n      = bit_cnt;
        shift_n    = shift;
        par_n      = par_bit;
        pop        = 1'b0;
        frame_done = 1'b0;
        baud_n     = (state == ST_IDLE || baud_last) ? '0 : baud_cnt + 1'b1;

        case (state)
            ST_IDLE: begin
                if (level != '0) pop = 1'b1;
            end
            ST_START: begin
                if (baud_last) begin
                    state_n = ST_DATA;
                    bit_n   = '0;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    shift_n = shift >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_n   = '0;
                        state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_last) begin
                    state_n = ST_STOP;
                    bit_n   = '0;
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    if (bit_cnt == STOP_LAST) begin
                        frame_done = 1'b1;
                        // Back-to-back frames chain straight into START with no idle bit.
                        if (level != '0) pop = 1'b1;
                        else             state_n = ST_IDLE;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (pop) begin
            state_n = ST_START;
            shift_n = head;
            par_n   = (PARITY == 2) ? ~(^head) : ^head;
        end

        // tx is registered, so it is derived from the state being entered.
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = shift_n[0];
            ST_PARITY: tx_n = par_n;
            default:   tx_n = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; always_comb above uses blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            par_bit  <= par_n;
            tx       <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: four configurations share one stimulus path,
// a serial monitor decodes frames and compares them against a scoreboard queue.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] in_data;
    logic       in_valid;
    int         sel;

    logic       tx_a   [4];
    logic       rdy_a  [4];
    logic       busy_a [4];
    logic       fd_a   [4];
    logic [2:0] lvl0;
    logic [3:0] lvl1, lvl2, lvl3;

    logic       m_tx, m_rdy, m_busy, m_fd;
    logic [3:0] m_lvl;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int fd_cnt   = 0;

    logic [15:0] sb_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // sel 0: 8N1, DEPTH 4
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_valid(in_valid && sel == 0),
        .in_ready(rdy_a[0]), .tx(tx_a[0]), .busy(busy_a[0]), .level(lvl0), .frame_done(fd_a[0]));
    // sel 1: 8E1
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DEPTH(8)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_valid(in_valid && sel == 1),
        .in_ready(rdy_a[1]), .tx(tx_a[1]), .busy(busy_a[1]), .level(lvl1), .frame_done(fd_a[1]));
    // sel 2: 8O1
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DEPTH(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_valid(in_valid && sel == 2),
        .in_ready(rdy_a[2]), .tx(tx_a[2]), .busy(busy_a[2]), .level(lvl2), .frame_done(fd_a[2]));
    // sel 3: 7N2
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .DEPTH(8)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data[6:0]), .in_valid(in_valid && sel == 3),
        .in_ready(rdy_a[3]), .tx(tx_a[3]), .busy(busy_a[3]), .level(lvl3), .frame_done(fd_a[3]));

    always_comb begin
        m_tx   = tx_a[0];
        m_rdy  = rdy_a[0];
        m_busy = busy_a[0];
        m_fd   = fd_a[0];
        m_lvl  = {1'b0, lvl0};
        case (sel)
            1: begin m_tx = tx_a[1]; m_rdy = rdy_a[1]; m_busy = busy_a[1]; m_fd = fd_a[1]; m_lvl = lvl1; end
            2: begin m_tx = tx_a[2]; m_rdy = rdy_a[2]; m_busy = busy_a[2]; m_fd = fd_a[2]; m_lvl = lvl2; end
            3: begin m_tx = tx_a[3]; m_rdy = rdy_a[3]; m_busy = busy_a[3]; m_fd = fd_a[3]; m_lvl = lvl3; end
            default: ;
        endcase
    end

    function automatic int cfg_db(input int s);  return (s == 3) ? 7 : 8; endfunction
    function automatic int cfg_par(input int s); return (s == 1) ? 1 : (s == 2) ? 2 : 0; endfunction
    function automatic int cfg_sb(input int s);  return (s == 3) ? 2 : 1; endfunction
    function automatic int nbits(input int s);
        return 1 + cfg_db(s) + ((cfg_par(s) != 0) ? 1 : 0) + cfg_sb(s);
    endfunction

    // Reference frame: bit i is the line level during bit period i; unused tail is high.
    function automatic logic [15:0] make_frame(input int s, input logic [8:0] d);
        logic [15:0] f;
        logic        p;
        int          n;
        f    = '1;
        f[0] = 1'b0;
        p    = 1'b0;
        for (int i = 0; i < cfg_db(s); i++) begin
            f[1 + i] = d[i];
            p        = p ^ d[i];
        end
        n = 1 + cfg_db(s);
        if (cfg_par(s) != 0) begin
            f[n] = (cfg_par(s) == 1) ? p : ~p;
            n++;
        end
        for (int i = 0; i < cfg_sb(s); i++) begin
            f[n] = 1'b1;
            n++;
        end
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Serial monitor: samples mid-bit and pops the scoreboard once a whole frame is seen.
    logic        prev_tx = 1'b1;
    bit          cap_active = 1'b0;
    int          cap_cnt = 0;
    logic [15:0] cap_frame = '1;

    always @(negedge clk) begin
        if (rst) begin
            cap_active = 1'b0;
        end else begin
            if (!cap_active) begin
                if (prev_tx === 1'b1 && m_tx === 1'b0) begin
                    cap_active = 1'b1;
                    cap_cnt    = 0;
                    cap_frame  = '1;
                end
            end else begin
                cap_cnt++;
            end
            if (cap_active && (cap_cnt % 4) == 2) begin
                cap_frame[cap_cnt / 4] = m_tx;
                if (cap_cnt / 4 == nbits(sel) - 1) begin
                    cap_active = 1'b0;
                    if (sb_q.size() == 0) check("sb_unexpected_frame", cap_frame, 16'hxxxx);
                    else                  check("sb_frame", cap_frame, sb_q.pop_front());
                end
            end
        end
        prev_tx = m_tx;
        if (m_fd === 1'b1) fd_cnt++;
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic push(input logic [8:0] d);
        int t;
        t        = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (m_rdy !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("push_ready", m_rdy, 1);
        sb_q.push_back(make_frame(sel, d));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int t;
        t = 0;
        while (m_busy !== 1'b0 && t < lim) begin
            @(negedge clk);
            t++;
        end
        check("wait_idle", m_busy, 0);
    endtask

    typedef struct {
        int         cfg;
        logic [8:0] data;
        int         exp_len;
        int         exp_par;   // 2 = no parity bit in this frame
    } vec_t;

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          c, t0, fd0, par_s;
        bit          fd_seen;
        logic [9:0]  a5_bits;

        vecs[0] = '{0, 9'h0A5, 40, 2};
        vecs[1] = '{0, 9'h000, 40, 2};
        vecs[2] = '{0, 9'h0FF, 40, 2};
        vecs[3] = '{1, 9'h007, 44, 1};
        vecs[4] = '{2, 9'h007, 44, 0};
        vecs[5] = '{1, 9'h003, 44, 0};
        vecs[6] = '{2, 9'h003, 44, 1};
        vecs[7] = '{3, 9'h055, 40, 2};

        sel      = 0;
        in_valid = 1'b0;
        in_data  = '0;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset state of every configuration
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            check("rst_tx", m_tx, 1);
            check("rst_ready", m_rdy, 1);
            check("rst_busy", m_busy, 0);
            check("rst_level", m_lvl, 0);
            check("rst_frame_done", m_fd, 0);
        end
        sel = 0;
        @(negedge clk);

        // 0xA5 8N1: exact per-cycle waveform, frame_done on cycle 40, busy falls at 41
        a5_bits = 10'b11_0100_1010;
        push(9'h0A5);
        check("a5_level_after_push", m_lvl, 1);
        check("a5_busy_after_push", m_busy, 1);
        check("a5_tx_before_pop", m_tx, 1);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            check($sformatf("a5_tx_c%0d", i), m_tx, a5_bits[(i - 1) / 4]);
            check($sformatf("a5_fd_c%0d", i), m_fd, (i == 40) ? 1 : 0);
            check($sformatf("a5_busy_c%0d", i), m_busy, 1);
        end
        @(negedge clk);
        check("a5_busy_c41", m_busy, 0);
        check("a5_fd_c41", m_fd, 0);

        // Table-driven frames: length from pop to frame_done, and the parity bit
        for (int i = 0; i < 8; i++) begin
            sel = vecs[i].cfg;
            #1;
            @(negedge clk);
            push(vecs[i].data);
            c       = 0;
            par_s   = 0;
            fd_seen = 1'b0;
            while (!fd_seen && c < 200) begin
                @(negedge clk);
                c++;
                if (c == (1 + cfg_db(sel)) * 4 + 2) par_s = int'(m_tx);
                if (m_fd === 1'b1) fd_seen = 1'b1;
            end
            check($sformatf("vec%0d_len", i), c, vecs[i].exp_len);
            if (vecs[i].exp_par != 2) check($sformatf("vec%0d_parity", i), par_s, vecs[i].exp_par);
            @(negedge clk);
            check($sformatf("vec%0d_idle", i), m_busy, 0);
        end

        // Word pushed on the edge that ends STOP waits one idle cycle
        sel = 0;
        #1;
        @(negedge clk);
        push(9'h03C);
        c = 0;
        while (m_fd !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("late_fd_seen", m_fd, 1);
        push(9'h05A);
        check("late_idle_bit", m_tx, 1);
        check("late_busy", m_busy, 1);
        @(negedge clk);
        check("late_start", m_tx, 0);
        wait_idle(100);

        // DEPTH=4 streaming: push/pop at level 1, full at 4, six gapless frames
        @(negedge clk);
        fd0 = fd_cnt;
        push(9'h011);
        t0 = cyc;
        push(9'h022);
        check("pp_level_same_cycle", m_lvl, 1);
        push(9'h033);
        push(9'h044);
        push(9'h055);
        check("full_level", m_lvl, 4);
        check("full_ready", m_rdy, 0);
        push(9'h066);
        wait_idle(400);
        check("stream_cycles", cyc - t0, 241);
        check("stream_frames", fd_cnt - fd0, 6);
        check("stream_sb_empty", sb_q.size(), 0);

        // 7N2: two stop periods (8 cycles high) then the next start bit
        sel = 3;
        #1;
        @(negedge clk);
        push(9'h055);
        push(9'h02A);
        for (int i = 2; i <= 41; i++) begin
            @(negedge clk);
            if (i >= 32) check($sformatf("s2_tx_c%0d", i), m_tx, (i == 41) ? 0 : 1);
            if (i >= 32) check($sformatf("s2_fd_c%0d", i), m_fd, (i == 40) ? 1 : 0);
        end
        wait_idle(100);
        check("s2_sb_empty", sb_q.size(), 0);

        // Reset during data bit 3 with two words queued
        sel = 0;
        #1;
        @(negedge clk);
        push(9'h081);
        push(9'h042);
        push(9'h024);
        repeat (14) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_tx", m_tx, 1);
        check("mid_rst_level", m_lvl, 0);
        check("mid_rst_ready", m_rdy, 1);
        check("mid_rst_busy", m_busy, 0);
        fd0 = fd_cnt;
        repeat (60) @(negedge clk);
        check("mid_rst_no_fd", fd_cnt - fd0, 0);
        check("mid_rst_line_idle", m_tx, 1);
        push(9'h0C3);
        wait_idle(100);
        check("post_rst_frames", fd_cnt - fd0, 1);
        check("post_rst_sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
